// File: rtl/alu_shift_sequencer_if.sv
// Request/result handshake bundle between a shift requester and the shift sequencer.
// The master drives requests and consumes results; the slave is the sequencer.
interface alu_shift_sequencer_if;
    logic        Req_valid;
    logic        Req_ready;
    logic [1:0]  Req_op;
    logic [31:0] Req_operand;
    logic [7:0]  Req_amount;
    logic        Req_set_flags;
    logic        Res_valid;
    logic        Res_ready;
    logic [31:0] Res_data;
    logic        Res_carry;
    logic        Res_zero;
    logic        Res_neg;

    modport master (
        output Req_valid, Req_op, Req_operand, Req_amount, Req_set_flags, Res_ready,
        input  Req_ready, Res_valid, Res_data, Res_carry, Res_zero, Res_neg
    );

    modport slave (
        input  Req_valid, Req_op, Req_operand, Req_amount, Req_set_flags, Res_ready,
        output Req_ready, Res_valid, Res_data, Res_carry, Res_zero, Res_neg
    );
endinterface

// File: rtl/alu_shift_sequencer.sv
// Multi-pass control stage for a combinational 32-bit right shifter: splits shift
// amounts of 0..255 into passes of at most MAX_PASS_DIST bits and owns the C flag.
module alu_shift_sequencer #(
    parameter int MAX_PASS_DIST = 31
) (
    input  logic [4:0]  LOGISIM_CLOCK_TREE_0,
    input  logic        Reset,
    alu_shift_sequencer_if.slave bus,
    output logic [31:0] Op_Input,
    output logic [4:0]  Shift_distance,
    output logic [1:0]  Shift_func_sel,
    output logic        C,
    input  logic [31:0] Shift_Out
);
    localparam logic [7:0] MAX_D = 8'(MAX_PASS_DIST);
    localparam logic [1:0] OP_LSR = 2'd0;
    localparam logic [1:0] OP_ASR = 2'd1;
    localparam logic [1:0] OP_ROR = 2'd2;
    localparam logic [1:0] OP_RRX = 2'd3;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    logic clk;
    assign clk = LOGISIM_CLOCK_TREE_0[4];
    logic unused_clk_tree_bits;
    assign unused_clk_tree_bits = ^LOGISIM_CLOCK_TREE_0[3:0];

    state_t      state_reg, state_next;
    logic [1:0]  op_reg, op_next;
    logic        set_flags_reg, set_flags_next;
    logic [7:0]  rem_reg, rem_next;
    logic [31:0] work_reg, work_next;
    logic        carry_reg, carry_next;
    logic        c_reg, c_next;
    logic [31:0] op_input_reg, op_input_next;
    logic [4:0]  dist_reg, dist_next;
    logic [1:0]  sel_reg, sel_next;

    logic [7:0]  accept_rem;
    logic [7:0]  rem_after;

    function automatic logic [4:0] clamp_dist(input logic [7:0] r);
        return (r > MAX_D) ? MAX_D[4:0] : r[4:0];
    endfunction

    // ROR only needs the amount modulo 32; RRX is always a single 1-bit pass.
    always_comb begin
        case (bus.Req_op)
            OP_ROR:  accept_rem = {3'b000, bus.Req_amount[4:0]};
            OP_RRX:  accept_rem = 8'd1;
            default: accept_rem = bus.Req_amount;
        endcase
    end

    assign rem_after = rem_reg - {3'b000, dist_reg};

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        set_flags_next = set_flags_reg;
        rem_next       = rem_reg;
        work_next      = work_reg;
        carry_next     = carry_reg;
        c_next         = c_reg;
        op_input_next  = op_input_reg;
        dist_next      = dist_reg;
        sel_next       = sel_reg;
        case (state_reg)
            IDLE: begin
                if (bus.Req_valid) begin
                    op_next        = bus.Req_op;
                    set_flags_next = bus.Req_set_flags;
                    work_next      = bus.Req_operand;
                    rem_next       = accept_rem;
                    if (accept_rem == 8'd0) begin
                        // Zero-pass: amount 0 keeps C, ROR by a multiple of 32 yields bit 31.
                        state_next = DONE;
                        carry_next = (bus.Req_amount == 8'd0) ? c_reg : bus.Req_operand[31];
                    end else begin
                        state_next    = SHIFT;
                        op_input_next = bus.Req_operand;
                        dist_next     = clamp_dist(accept_rem);
                        sel_next      = bus.Req_op;
                    end
                end
            end
            SHIFT: begin
                work_next  = Shift_Out;
                carry_next = (op_reg == OP_RRX) ? op_input_reg[0]
                                                : op_input_reg[dist_reg - 5'd1];
                rem_next   = rem_after;
                if (rem_after == 8'd0) begin
                    state_next = DONE;
                end else begin
                    op_input_next = Shift_Out;
                    dist_next     = clamp_dist(rem_after);
                end
            end
            DONE: begin
                if (bus.Res_ready) begin
                    if (set_flags_reg) begin
                        c_next = carry_reg;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_reg     <= IDLE;
            op_reg        <= OP_LSR;
            set_flags_reg <= 1'b0;
            rem_reg       <= 8'd0;
            work_reg      <= 32'd0;
            carry_reg     <= 1'b0;
            c_reg         <= 1'b0;
            op_input_reg  <= 32'd0;
            dist_reg      <= 5'd0;
            sel_reg       <= 2'd0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            set_flags_reg <= set_flags_next;
            rem_reg       <= rem_next;
            work_reg      <= work_next;
            carry_reg     <= carry_next;
            c_reg         <= c_next;
            op_input_reg  <= op_input_next;
            dist_reg      <= dist_next;
            sel_reg       <= sel_next;
        end
    end

    assign bus.Req_ready = (state_reg == IDLE) && !Reset;
    assign bus.Res_valid = (state_reg == DONE);
    assign bus.Res_data  = work_reg;
    assign bus.Res_carry = carry_reg;
    assign bus.Res_zero  = (work_reg == 32'd0);
    assign bus.Res_neg   = work_reg[31];

    assign Op_Input       = op_input_reg;
    assign Shift_distance = dist_reg;
    assign Shift_func_sel = sel_reg;
    assign C              = c_reg;

    // OP_ASR is named for readability of the op encoding only.
    logic unused_op_asr;
    assign unused_op_asr = ^OP_ASR;
endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Bench for alu_shift_sequencer: behavioural shift unit, full-amount reference model,
// vector table plus randomised requests checked through an expected-result queue.
module tb_alu_shift_sequencer;
    logic        clk;
    logic [4:0]  clk_tree;
    logic        Reset;
    logic [31:0] Op_Input;
    logic [4:0]  Shift_distance;
    logic [1:0]  Shift_func_sel;
    logic        C;
    logic [31:0] Shift_Out;

    alu_shift_sequencer_if bus ();

    assign clk_tree = {clk, 4'b0000};

    alu_shift_sequencer #(.MAX_PASS_DIST(31)) dut (
        .LOGISIM_CLOCK_TREE_0(clk_tree),
        .Reset(Reset),
        .bus(bus.slave),
        .Op_Input(Op_Input),
        .Shift_distance(Shift_distance),
        .Shift_func_sel(Shift_func_sel),
        .C(C),
        .Shift_Out(Shift_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational shift unit driven by the sequencer.
    always_comb begin
        logic [63:0] dbl;
        dbl = {Op_Input, Op_Input} >> Shift_distance;
        case (Shift_func_sel)
            2'd0:    Shift_Out = Op_Input >> Shift_distance;
            2'd1:    Shift_Out = 32'($signed(Op_Input) >>> Shift_distance);
            2'd2:    Shift_Out = dbl[31:0];
            default: Shift_Out = {C, Op_Input[31:1]};
        endcase
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] operand;
        logic [7:0]  amount;
        logic        sf;
        int          delay;
        logic [31:0] exp_data;
        logic        exp_carry;
        int          exp_passes;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        carry;
        logic        sf;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic c_model = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    function automatic logic [32:0] ref_shift(input logic [1:0] op, input logic [31:0] x,
                                              input logic [7:0] n, input logic c);
        logic [63:0] dbl;
        int r;
        if (op == 2'd3) return {x[0], c, x[31:1]};
        if (n == 8'd0) return {c, x};
        case (op)
            2'd0: begin
                if (n < 32) return {x[n-1], x >> n};
                if (n == 32) return {x[31], 32'd0};
                return 33'd0;
            end
            2'd1: begin
                if (n < 32) return {x[n-1], 32'($signed(x) >>> n)};
                return {x[31], {32{x[31]}}};
            end
            default: begin
                r = int'(n) % 32;
                if (r == 0) return {x[31], x};
                dbl = {x, x} >> r;
                return {x[r-1], dbl[31:0]};
            end
        endcase
    endfunction

    function automatic int passes_for(input logic [1:0] op, input logic [7:0] n);
        int rem;
        if (op == 2'd3) rem = 1;
        else if (op == 2'd2) rem = int'(n) % 32;
        else rem = int'(n);
        return (rem + 30) / 31;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   cyc;
        exp_t e;
        logic [31:0] snap_data;
        logic snap_carry;
        bus.Req_op        = v.op;
        bus.Req_operand   = v.operand;
        bus.Req_amount    = v.amount;
        bus.Req_set_flags = v.sf;
        bus.Req_valid     = 1'b1;
        cyc = 0;
        while (!bus.Req_ready && cyc < 50) begin tick(); cyc++; end
        if (!bus.Req_ready) begin
            errors++; checks++;
            $display("FAIL accept_timeout[%0d]: Req_ready never rose", idx);
            bus.Req_valid = 1'b0;
            return;
        end
        exp_q.push_back('{data: v.exp_data, carry: v.exp_carry, sf: v.sf});
        tick();
        bus.Req_valid = 1'b0;
        cyc = 0;
        while (!bus.Res_valid && cyc < 20) begin tick(); cyc++; end
        if (!bus.Res_valid) begin
            errors++; checks++;
            $display("FAIL result_timeout[%0d]: Res_valid never rose", idx);
            void'(exp_q.pop_front());
            return;
        end
        check($sformatf("latency[%0d]", idx), cyc, v.exp_passes);
        snap_data  = bus.Res_data;
        snap_carry = bus.Res_carry;
        // Hold the result back while another request is offered; it must be ignored.
        for (int k = 0; k < v.delay; k++) begin
            bus.Req_valid   = 1'b1;
            bus.Req_op      = 2'd0;
            bus.Req_amount  = 8'd3;
            tick();
            check($sformatf("hold_ready[%0d]", idx), bus.Req_ready, 0);
            check($sformatf("hold_valid[%0d]", idx), bus.Res_valid, 1);
            check($sformatf("hold_data[%0d]", idx), bus.Res_data, snap_data);
            check($sformatf("hold_carry[%0d]", idx), bus.Res_carry, snap_carry);
        end
        bus.Req_valid = 1'b0;
        bus.Res_ready = 1'b1;
        e = exp_q.pop_front();
        check($sformatf("data[%0d]", idx), bus.Res_data, e.data);
        check($sformatf("carry[%0d]", idx), bus.Res_carry, e.carry);
        check($sformatf("zero[%0d]", idx), bus.Res_zero, (e.data == 32'd0));
        check($sformatf("neg[%0d]", idx), bus.Res_neg, e.data[31]);
        $display("txn %0d: op=%0d operand=0x%08h amt=%0d sf=%0d -> data=0x%08h carry=%0d passes=%0d",
                 idx, v.op, v.operand, v.amount, v.sf, bus.Res_data, bus.Res_carry, cyc);
        tick();
        bus.Res_ready = 1'b0;
        if (e.sf) c_model = e.carry;
        check($sformatf("valid_drop[%0d]", idx), bus.Res_valid, 0);
        check($sformatf("idle_ready[%0d]", idx), bus.Req_ready, 1);
        check($sformatf("c_flag[%0d]", idx), C, c_model);
    endtask

    vec_t tbl[16];
    vec_t rv;
    logic [32:0] r;

    initial begin
        tbl[0]  = '{2'd0, 32'h80000001, 8'd1,   1'b1, 0, 32'h40000000, 1'b1, 1};
        tbl[1]  = '{2'd1, 32'h80000000, 8'd40,  1'b0, 0, 32'hFFFFFFFF, 1'b1, 2};
        tbl[2]  = '{2'd0, 32'h80000000, 8'd32,  1'b0, 1, 32'h00000000, 1'b1, 2};
        tbl[3]  = '{2'd2, 32'h00000001, 8'd33,  1'b0, 0, 32'h80000000, 1'b1, 1};
        tbl[4]  = '{2'd2, 32'h12345678, 8'd64,  1'b0, 0, 32'h12345678, 1'b0, 0};
        tbl[5]  = '{2'd3, 32'h00000002, 8'd0,   1'b1, 0, 32'h80000001, 1'b0, 1};
        tbl[6]  = '{2'd3, 32'h00000003, 8'd0,   1'b0, 0, 32'h00000001, 1'b1, 1};
        tbl[7]  = '{2'd0, 32'hDEADBEEF, 8'd0,   1'b0, 5, 32'hDEADBEEF, 1'b0, 0};
        tbl[8]  = '{2'd0, 32'hFFFFFFFF, 8'd255, 1'b1, 0, 32'h00000000, 1'b0, 9};
        tbl[9]  = '{2'd1, 32'h40000000, 8'd255, 1'b0, 0, 32'h00000000, 1'b0, 9};
        tbl[10] = '{2'd2, 32'h0000000F, 8'd4,   1'b0, 2, 32'hF0000000, 1'b1, 1};
        tbl[11] = '{2'd0, 32'h80000000, 8'd31,  1'b1, 0, 32'h00000001, 1'b0, 1};
        tbl[12] = '{2'd0, 32'h00000001, 8'd1,   1'b1, 0, 32'h00000000, 1'b1, 1};
        tbl[13] = '{2'd1, 32'h80000000, 8'd0,   1'b0, 0, 32'h80000000, 1'b1, 0};
        tbl[14] = '{2'd2, 32'hA5A5A5A5, 8'd63,  1'b0, 0, 32'h4B4B4B4B, 1'b0, 1};
        tbl[15] = '{2'd0, 32'hFFFFFFFF, 8'd33,  1'b0, 0, 32'h00000000, 1'b0, 2};

        Reset = 1'b1;
        bus.Req_valid = 1'b0;
        bus.Req_op = 2'd0;
        bus.Req_operand = 32'd0;
        bus.Req_amount = 8'd0;
        bus.Req_set_flags = 1'b0;
        bus.Res_ready = 1'b0;
        repeat (3) tick();
        check("rst_req_ready", bus.Req_ready, 0);
        check("rst_res_valid", bus.Res_valid, 0);
        check("rst_res_data", bus.Res_data, 0);
        check("rst_c", C, 0);
        Reset = 1'b0;
        #1;
        check("rst_release_ready", bus.Req_ready, 1);

        for (int i = 0; i < 16; i++) run_vec(tbl[i], i);

        // Reset in the middle of a long LSR: request abandoned, C cleared, no result.
        check("pre_reset_c", C, 1);
        bus.Req_op = 2'd0; bus.Req_operand = 32'h80000000;
        bus.Req_amount = 8'd200; bus.Req_set_flags = 1'b1; bus.Req_valid = 1'b1;
        tick();
        bus.Req_valid = 1'b0;
        repeat (2) tick();
        check("mid_shift_dist", Shift_distance, 31);
        Reset = 1'b1;
        tick();
        check("rst_mid_ready", bus.Req_ready, 0);
        tick();
        check("rst_mid_ready2", bus.Req_ready, 0);
        check("rst_mid_opin", Op_Input, 0);
        check("rst_mid_dist", Shift_distance, 0);
        check("rst_mid_sel", Shift_func_sel, 0);
        check("rst_mid_data", bus.Res_data, 0);
        check("rst_mid_carry", bus.Res_carry, 0);
        Reset = 1'b0;
        #1;
        check("rst_mid_release_ready", bus.Req_ready, 1);
        check("rst_mid_c", C, 0);
        c_model = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("rst_mid_no_valid", bus.Res_valid, 0);
            tick();
        end

        for (int i = 0; i < 24; i++) begin
            rv.op = 2'($urandom_range(0, 3));
            rv.operand = $urandom;
            case ($urandom_range(0, 3))
                0: rv.amount = 8'($urandom_range(0, 2));
                1: rv.amount = 8'($urandom_range(30, 34));
                2: rv.amount = 8'($urandom_range(60, 66));
                default: rv.amount = 8'($urandom_range(0, 255));
            endcase
            rv.sf = 1'($urandom_range(0, 1));
            rv.delay = $urandom_range(0, 2);
            r = ref_shift(rv.op, rv.operand, rv.amount, c_model);
            rv.exp_data = r[31:0];
            rv.exp_carry = r[32];
            rv.exp_passes = passes_for(rv.op, rv.amount);
            run_vec(rv, 100 + i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_shift_sequencer.md
Name: alu_shift_sequencer

Overview:
Control stage wrapped around the combinational 32-bit right-shift unit. It accepts shift requests over a valid/ready handshake and drives the shift unit's operand, distance and function-select inputs. It iterates in passes of at most 31 bits so register-specified amounts of 0..255 are supported, and it registers each pass result. It owns the architectural C flag, which it feeds back to the shift unit for RRX, and returns the result with C/Z/N flags over a second valid/ready handshake.

Parameters:
MAX_PASS_DIST, 31, largest distance issued to the shift unit in one pass (fixed by its 5-bit distance port).

Ports:
LOGISIM_CLOCK_TREE_0  in  5  clock tree bundle; bit 4 = global clock, all flops on its rising edge; other bits unused
Reset  in  1  synchronous, active-high reset
Req_valid  in  1  request present
Req_ready  out  1  sequencer can accept (high only in IDLE)
Req_op  in  2  0=LSR, 1=ASR, 2=ROR, 3=RRX
Req_operand  in  32  value to shift
Req_amount  in  8  shift amount 0..255; ignored for RRX
Req_set_flags  in  1  update C flag on result handoff
Op_Input  out  32  to shift unit operand
Shift_distance  out  5  to shift unit distance
Shift_func_sel  out  2  to shift unit select, equals latched op
C  out  1  current C flag, to shift unit carry input
Shift_Out  in  32  result from shift unit (combinational)
Res_valid  out  1  result available
Res_ready  in  1  consumer takes result
Res_data  out  32  final result
Res_carry  out  1  carry-out of operation
Res_zero  out  1  Res_data == 0
Res_neg  out  1  Res_data[31]

Behaviour:
- Reset (synchronous, dominates all other inputs): state=IDLE; Res_valid=0; Res_data=0; Res_carry=0; C=0; Op_Input=0; Shift_distance=0; Shift_func_sel=0. Req_ready is forced 0 in any cycle in which Reset=1.
- Reset mid-operation: the request is abandoned, no result is produced and C is not updated.
- States:
  - IDLE: Req_ready=1. On Req_valid, latch op, operand and set_flags into the work registers.
  - Computing rem on accept: LSR/ASR: rem = amount. ROR: rem = amount mod 32. RRX: rem = 1.
  - Leaving IDLE on accept: go to DONE directly when LSR/ASR/ROR amount==0 (result=operand, carry=C) or when ROR amount!=0 with amount mod 32==0 (result=operand, carry=operand[31]). Otherwise go to SHIFT.
  - SHIFT: drive Op_Input=work, Shift_distance=d=min(rem,31), Shift_func_sel=op. At the clock edge: work<=Shift_Out; carry<=work[d-1], except RRX, where carry<=work[0]; rem<=rem-d. Go to DONE when rem-d==0, else stay in SHIFT.
  - DONE: Res_valid=1; Res_data/Res_carry/Res_zero/Res_neg are stable while Res_ready=0. When Res_ready=1: if set_flags, C<=Res_carry; Res_valid drops the next cycle; go to IDLE.
- Outputs to the shift unit hold their last driven values outside SHIFT.
- Latency: the accept cycle is followed by P SHIFT cycles, with P=ceil(rem/31) (1..9). Res_valid rises on the edge that ends the last pass. Zero-pass cases raise Res_valid on the edge after accept.
- Throughput: no overlap. The next request is accepted at the earliest one cycle after the DONE handoff.
- Required arithmetic results:
  - LSR n>=32: data=0; carry=operand[31] if n==32, else 0.
  - ASR n>=32: data and carry = sign fill of operand[31].
  - RRX: data={C, operand[31:1]}, using the C value at issue time; carry=operand[0].
- Res_zero and Res_neg are combinational from the registered Res_data.
- Req_valid while not IDLE: not accepted; the requester holds the request.

Test Plan:
- Reset held 2 cycles mid-SHIFT of LSR 200 -> all outputs at reset values, Req_ready=1 the cycle after Reset falls, C=0, no Res_valid.
- LSR operand=0x80000001, amount=1, set_flags=1 -> Res_valid 2 edges after accept; data=0x40000000, carry=1, Z=0, N=0; C=1 after handoff.
- ASR operand=0x80000000, amount=40 -> 2 passes (31, 9); data=0xFFFFFFFF, carry=1, N=1. LSR same operand with amount=32 -> data=0, carry=1, Z=1.
- ROR operand=0x00000001, amount=33 -> one pass of 1; data=0x80000000, carry=1. ROR amount=64 -> zero passes; data=operand, carry=operand[31].
- C=1, RRX operand=0x00000002 -> data=0x80000001, carry=0. With set_flags=1, C becomes 0; a following RRX uses the new C.
- Res_ready held low 5 cycles -> Res_* stable, Req_ready=0, Req_valid ignored. Same-cycle Res_ready -> IDLE next cycle, accept the cycle after.
